// File: rtl/mc_ctl_pkg.sv
// Shared constants and state encoding for the multi-cycle MIPS32 main controller.
// MC_CTL_IMM_EN adds the addi/ori states.
package mc_ctl_pkg;

  localparam int unsigned OpcodeLen = 6;
  localparam int unsigned AluopLen  = 2;

  localparam logic [OpcodeLen-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OpcodeLen-1:0] OP_LW    = 6'b100011;
  localparam logic [OpcodeLen-1:0] OP_SW    = 6'b101011;
  localparam logic [OpcodeLen-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OpcodeLen-1:0] OP_J     = 6'b000010;
  localparam logic [OpcodeLen-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OpcodeLen-1:0] OP_ORI   = 6'b001101;

  localparam logic [AluopLen-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [AluopLen-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [AluopLen-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [AluopLen-1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Encodings are fixed so the optional states never shift the base ones.
  typedef enum logic [3:0] {
    StRst     = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRtypeEx = 4'd7,
    StRtypeWb = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StErr     = 4'd11
`ifdef MC_CTL_IMM_EN
    ,
    StImmEx   = 4'd12,
    StImmWb   = 4'd13
`endif
  } state_e;

  function automatic logic is_mem_wait(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_ctl_wdog.sv
// Memory-access watchdog: counts unacknowledged wait cycles and flags expiry
// on the last allowed cycle. MEM_TIMEOUT = 0 disables it.
module mc_ctl_wdog #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned Lim  = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam bit          En   = (MEM_TIMEOUT != 0);

  logic [CntW-1:0] cnt_q;

  // Leaving a wait state always passes through a non-busy state or an ack,
  // so clearing on !busy || ack also covers "clear on state change".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!busy || ack || expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expire = En && busy && !ack && (cnt_q == CntW'(Lim));

endmodule

// File: rtl/mc_ctl.sv
// Multi-cycle MIPS32 main controller: fetch/decode/execute/mem/write-back FSM.
// Define MC_CTL_IMM_EN to support addi/ori via IMM_EX/IMM_WB.
module mc_ctl
  import mc_ctl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OpcodeLen-1:0] OpCode,
  input  logic                 Zero,
  input  logic                 mem_ack,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRd,
  output logic                 MemWr,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWr,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [AluopLen-1:0]  ALUOp,
  output logic [1:0]           PCSource,
  output logic                 err,
  output logic [CNT_W-1:0]     instret
);

  state_e           state_q, state_d;
  logic             expire;
  logic             retire;
  logic [CNT_W-1:0] instret_q;

  // Zero is qualified by PCWriteCond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = Zero;

  mc_ctl_wdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (is_mem_wait(state_q)),
    .ack   (mem_ack),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRst;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

`ifdef MC_CTL_IMM_EN
  logic imm_ori_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_ori_q <= 1'b0;
    end else if (state_q == StDecode) begin
      imm_ori_q <= (OpCode == OP_ORI);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:     state_d = StFetch;
      StFetch: begin
        if (mem_ack)     state_d = StDecode;
        else if (expire) state_d = StErr;
      end
      StDecode: begin
        case (OpCode)
          OP_RTYPE:     state_d = StRtypeEx;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
`ifdef MC_CTL_IMM_EN
          OP_ADDI, OP_ORI: state_d = StImmEx;
`endif
          default:      state_d = StErr;
        endcase
      end
      StMemAdr:  state_d = (OpCode == OP_SW) ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ack)     state_d = StMemWb;
        else if (expire) state_d = StErr;
      end
      StMemWb:   state_d = StFetch;
      StMemWr: begin
        if (mem_ack)     state_d = StFetch;
        else if (expire) state_d = StErr;
      end
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
`ifdef MC_CTL_IMM_EN
      StImmEx:   state_d = StImmWb;
      StImmWb:   state_d = StFetch;
`endif
      StErr:     state_d = StErr;
      default:   state_d = StErr;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRd       = 1'b0;
    MemWr       = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWr       = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    unique case (state_q)
      StFetch: begin
        MemRd   = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ack;
        PCWrite = mem_ack;
      end
      StDecode:  ALUSrcB = SRCB_IMM_SH2;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      StMemRd: begin
        MemRd = 1'b1;
        IorD  = 1'b1;
      end
      StMemWb: begin
        RegWr    = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWr = 1'b1;
        IorD  = 1'b1;
      end
      StRtypeEx: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      StRtypeWb: begin
        RegWr  = 1'b1;
        RegDst = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
`ifdef MC_CTL_IMM_EN
      StImmEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = imm_ori_q ? ALUOP_OR : ALUOP_ADD;
      end
      StImmWb:   RegWr = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      StMemWb, StRtypeWb, StBranch, StJump: retire = 1'b1;
      StMemWr:                               retire = mem_ack;
`ifdef MC_CTL_IMM_EN
      StImmWb:                               retire = 1'b1;
`endif
      default:                               retire = 1'b0;
    endcase
  end

  assign err     = (state_q == StErr);
  assign instret = instret_q;

endmodule
